if_scratch_read_ctrl: RTL and testbench
=======================================

// Module: if_scratch_read_ctrl
// PURPOSE
//  Consumer side of the IF scratchpad circular buffer. The IF write side fills the buffer and publishes
//  start_IF/end_IF/IF_end_valid. This block walks one complete row as sliding windows: filt_len taps
//  per window, advancing by stride. It issues scratchpad read addresses to the PE datapath under a
//  valid/ready handshake. After the last window it pulses full_done, which releases the row back to
//  the write side.
// PARAMETERS
//  ADDR_LEN       4   scratchpad address width
//  SCRATCH_DEPTH  16  scratchpad entries, <= 2**ADDR_LEN; all addresses wrap modulo this value
//  FILT_W         4   width of filt_len and stride
// PORTS
//  clk          in   1         clock; every flop updates on its rising edge
//  rst          in   1         asynchronous, active-low reset (0 = reset)
//  start        in   1         synchronous restart; clears all state and returns to IDLE
//  start_IF     in   ADDR_LEN  first scratch address of the current row
//  end_IF       in   ADDR_LEN  last scratch address of the current row
//  IF_end_valid in   1         1 = the full row [start_IF..end_IF] is resident in the scratchpad
//  filt_len     in   FILT_W    taps per window; 0 is treated as 1
//  stride       in   FILT_W    window advance; 0 is treated as 1
//  rd_ready     in   1         PE accepts the current address
//  IF_raddr     out  ADDR_LEN  scratchpad read address
//  rd_valid     out  1         IF_raddr is valid (also the scratchpad read enable)
//  win_first    out  1         tap index == 0, qualified by rd_valid
//  win_last     out  1         tap index == filt_len-1, qualified by rd_valid
//  full_done    out  1         one-cycle pulse: row finished, write side may advance start_IF
//  busy         out  1         1 in any state other than IDLE
// BEHAVIOUR
//  Reset (rst=0): state=IDLE; all outputs 0; counters and latches cleared.
//  start=1 in any state takes priority: next state IDLE, counters cleared, no full_done pulse.
//  States:
//   IDLE:  exits to WAIT_ROW on the first cycle with start=0.
//   WAIT_ROW: when IF_end_valid=1, latch row_base=start_IF, row_len=((end_IF-start_IF) mod DEPTH)+1
//          (width ADDR_LEN+1, range 1..DEPTH), F=max(filt_len,1), S=max(stride,1); clear o and k.
//          If F > row_len, go to DONE; otherwise go to READ.
//   READ:  rd_valid=1; IF_raddr=(row_base+o+k) mod DEPTH, computed in ADDR_LEN+2 bits.
//          IF_raddr is a function of registered state only; data arrives next cycle (PE concern).
//          On rd_valid & rd_ready:
//           - if k<F-1: k <= k+1.
//           - otherwise: k <= 0.
//             - if o+S+F <= row_len: o <= o+S.
//             - otherwise: go to DONE.
//          With rd_ready=0, IF_raddr/win_* hold stable and no state or counter changes.
//          Input changes after the latch in WAIT_ROW are ignored.
//   DONE:  full_done=1 for exactly one cycle; rd_valid=0; go to SETTLE.
//   SETTLE: one idle cycle so the write side can reload start_IF/end_IF; then go to WAIT_ROW.
//          IF_end_valid may already be 1 again (next row buffered); WAIT_ROW samples it then.
//  Windows per row = floor((row_len-F)/S)+1; reads per row = windows*F.
//  With rd_ready held 1, there is no bubble between windows.
//  Wrap: a row spanning the top of the buffer yields addresses that wrap DEPTH-1 -> 0.
//  The full-buffer row (row_len=DEPTH) is legal.
//  rd_valid never asserts outside READ, so the block never reads outside [start_IF..end_IF].
// TESTING
//  1. DEPTH=16, start_IF=0, end_IF=5, F=3, S=1, rd_ready=1
//     -> addrs 0,1,2,1,2,3,2,3,4,3,4,5; win_first on each 1st, win_last on each 3rd;
//        full_done 1 cycle after the last read.
//  2. start_IF=14, end_IF=3 (row_len 6), F=2, S=2 -> addrs 14,15,0,1,2,3; full_done once.
//  3. F=4, row_len=3 -> no rd_valid; full_done pulses 1 cycle after the WAIT_ROW latch.
//  4. Test 1 with rd_ready toggling 1,0,0,1...
//     -> IF_raddr stable while stalled; same address sequence; no duplicates or drops.
//  5. rst=0 mid-READ (o=2,k=1) -> all outputs 0 immediately.
//     After release and a start pulse -> row restarts from addr start_IF.
//  6. IF_end_valid stays 1 across full_done while the write side moves start_IF 6->12, end_IF=15
//     -> after SETTLE the new row is latched; first addr=12.

Source files
------------

// File: rtl/if_scratch_read_ctrl.sv
// Purpose: walks one resident IF row as sliding windows and issues scratchpad read addresses.
// Latency: the address is valid in the cycle after the row is latched; full_done follows the last accepted read by one cycle.
// Backpressure: rd_ready=0 freezes the address, the window flags and all counters until the PE accepts.
module if_scratch_read_ctrl #(
   parameter int ADDR_LEN      = 4,
   parameter int SCRATCH_DEPTH = 16,
   parameter int FILT_W        = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [ADDR_LEN-1:0] start_IF,
   input  logic [ADDR_LEN-1:0] end_IF,
   input  logic                IF_end_valid,
   input  logic [FILT_W-1:0]   filt_len,
   input  logic [FILT_W-1:0]   stride,
   input  logic                rd_ready,
   output logic [ADDR_LEN-1:0] IF_raddr,
   output logic                rd_valid,
   output logic                win_first,
   output logic                win_last,
   output logic                full_done,
   output logic                busy
);

   // Row length needs one extra bit so a full-buffer row (DEPTH entries) fits.
   localparam int LW = ADDR_LEN + 1;
   // Address sum base+o+k stays below 2*DEPTH; two extra bits give headroom.
   localparam int AW = ADDR_LEN + 2;
   // Comparison width covering o+S+F against row_len without overflow.
   localparam int CW = ((ADDR_LEN > FILT_W) ? ADDR_LEN : FILT_W) + 3;

   localparam logic [LW-1:0] DEPTH_L = LW'(SCRATCH_DEPTH);
   localparam logic [AW-1:0] DEPTH_A = AW'(SCRATCH_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_ROW = 3'd1,
      S_READ     = 3'd2,
      S_DONE     = 3'd3,
      S_SETTLE   = 3'd4
   } state_t;

   state_t state;
   state_t state_nxt;

   // Row geometry latched in WAIT_ROW; later input changes are ignored.
   logic [ADDR_LEN-1:0] row_base;
   logic [LW-1:0]       row_len;
   logic [FILT_W-1:0]   filt_q;
   logic [FILT_W-1:0]   stride_q;

   // Window offset (o) and tap index (k) within the current window.
   logic [LW-1:0]       win_o;
   logic [FILT_W-1:0]   tap_k;

   // Candidate geometry derived from the live inputs.
   logic [LW-1:0]       span_diff;
   logic [LW-1:0]       span_mod;
   logic [LW-1:0]       row_len_new;
   logic [FILT_W-1:0]   filt_new;
   logic [FILT_W-1:0]   stride_new;
   logic                row_too_short;

   // Per-cycle READ decisions.
   logic                last_tap;
   logic                next_fits;
   logic                accept;
   logic [AW-1:0]       addr_sum;
   logic [AW-1:0]       addr_mod;

   // A negative difference means the row wraps past DEPTH-1; add DEPTH back.
   assign span_diff     = {1'b0, end_IF} - {1'b0, start_IF};
   assign span_mod      = span_diff[ADDR_LEN] ? (span_diff + DEPTH_L) : span_diff;
   assign row_len_new   = span_mod + LW'(1);
   assign filt_new      = (filt_len == '0) ? FILT_W'(1) : filt_len;
   assign stride_new    = (stride == '0) ? FILT_W'(1) : stride;
   assign row_too_short = CW'(filt_new) > CW'(row_len_new);

   assign last_tap  = (tap_k == (filt_q - FILT_W'(1)));
   assign next_fits = (CW'(win_o) + CW'(stride_q) + CW'(filt_q)) <= CW'(row_len);
   assign accept    = (state == S_READ) && rd_ready;

   // o+k never exceeds DEPTH-1 and base < DEPTH, so one conditional subtract wraps.
   assign addr_sum = AW'(row_base) + AW'(win_o) + AW'(tap_k);
   assign addr_mod = (addr_sum >= DEPTH_A) ? (addr_sum - DEPTH_A) : addr_sum;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and output decode; start overrides every state.
   always_comb begin
      state_nxt = state;
      rd_valid  = 1'b0;
      IF_raddr  = '0;
      win_first = 1'b0;
      win_last  = 1'b0;
      full_done = 1'b0;
      busy      = (state != S_IDLE);

      if (start) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               state_nxt = S_WAIT_ROW;
            end
            S_WAIT_ROW: begin
               if (IF_end_valid) begin
                  state_nxt = row_too_short ? S_DONE : S_READ;
               end
            end
            S_READ: begin
               if (accept && last_tap && !next_fits) begin
                  state_nxt = S_DONE;
               end
            end
            S_DONE: begin
               state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
               state_nxt = S_WAIT_ROW;
            end
            default: begin
               state_nxt = S_IDLE;
            end
         endcase
      end

      if (state == S_READ) begin
         rd_valid  = 1'b1;
         IF_raddr  = addr_mod[ADDR_LEN-1:0];
         win_first = (tap_k == '0);
         win_last  = last_tap;
      end

      // A restart landing on the DONE cycle suppresses the release pulse.
      full_done = (state == S_DONE) && !start;
   end

   // Row latch and window/tap counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_base <= '0;
         row_len  <= '0;
         filt_q   <= '0;
         stride_q <= '0;
         win_o    <= '0;
         tap_k    <= '0;
      end else if (start) begin
         row_base <= '0;
         row_len  <= '0;
         filt_q   <= '0;
         stride_q <= '0;
         win_o    <= '0;
         tap_k    <= '0;
      end else begin
         case (state)
            S_WAIT_ROW: begin
               if (IF_end_valid) begin
                  row_base <= start_IF;
                  row_len  <= row_len_new;
                  filt_q   <= filt_new;
                  stride_q <= stride_new;
                  win_o    <= '0;
                  tap_k    <= '0;
               end
            end
            S_READ: begin
               if (rd_ready) begin
                  if (!last_tap) begin
                     tap_k <= tap_k + FILT_W'(1);
                  end else begin
                     tap_k <= '0;
                     if (next_fits) begin
                        win_o <= win_o + LW'(stride_q);
                     end
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // A stalled read must present the same address again on the next cycle.
   a_stall_stable: assert property (@(posedge clk) disable iff (!rst)
      (rd_valid && !rd_ready && !start) |=> (rd_valid && $stable(IF_raddr)));

   // The row-release pulse is never wider than one cycle.
   a_done_single: assert property (@(posedge clk) disable iff (!rst)
      full_done |=> !full_done);

   // Reads are only ever issued while the controller is active.
   a_read_busy: assert property (@(posedge clk) disable iff (!rst)
      rd_valid |-> busy);

endmodule

// File: tb/tb_if_scratch_read_ctrl.sv
module tb_if_scratch_read_ctrl;
   localparam int AL = 4;
   localparam int D  = 16;
   localparam int FW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [AL-1:0] start_IF = '0;
   logic [AL-1:0] end_IF = '0;
   logic          IF_end_valid = 1'b0;
   logic [FW-1:0] filt_len = '0;
   logic [FW-1:0] stride = '0;
   logic          rd_ready = 1'b0;
   logic [AL-1:0] IF_raddr;
   logic          rd_valid;
   logic          win_first;
   logic          win_last;
   logic          full_done;
   logic          busy;

   if_scratch_read_ctrl #(.ADDR_LEN(AL), .SCRATCH_DEPTH(D), .FILT_W(FW)) dut (
      .clk(clk), .rst(rst), .start(start),
      .start_IF(start_IF), .end_IF(end_IF), .IF_end_valid(IF_end_valid),
      .filt_len(filt_len), .stride(stride), .rd_ready(rd_ready),
      .IF_raddr(IF_raddr), .rd_valid(rd_valid), .win_first(win_first),
      .win_last(win_last), .full_done(full_done), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int addr;
      bit first;
      bit last;
   } rd_t;

   rd_t exp_q[$];
   rd_t row_buf[$];
   int  row_q[$];

   int pass_cnt = 0;
   int total_cnt = 0;
   int cyc = 0;
   int last_hs = 0;
   int reads_done = 0;
   bit prev_hs = 0;
   bit prev_fd = 0;
   bit hs_now = 0;
   bit chk_en = 0;
   int rdy_mode = 0;
   int rdy_idx = 0;

   task automatic chk(input bit ok, input string name, input int act, input int exp);
      total_cnt++;
      if (ok) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic finish_now();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   endtask

   // Reference: enumerate every window that fits, every tap in each window.
   function automatic int model_row(input int base, input int endv, input int f, input int s);
      int len;
      int ff;
      int ss;
      rd_t e;
      row_buf.delete();
      len = ((endv - base) % D + D) % D + 1;
      ff  = (f == 0) ? 1 : f;
      ss  = (s == 0) ? 1 : s;
      for (int o = 0; o + ff <= len; o += ss) begin
         for (int k = 0; k < ff; k++) begin
            e.addr  = (base + o + k) % D;
            e.first = (k == 0);
            e.last  = (k == ff - 1);
            row_buf.push_back(e);
         end
      end
      return row_buf.size();
   endfunction

   task automatic check_zero(input string tag);
      chk(IF_raddr == '0, {tag, "_raddr"}, int'(IF_raddr), 0);
      chk(rd_valid == 1'b0, {tag, "_rd_valid"}, int'(rd_valid), 0);
      chk(win_first == 1'b0, {tag, "_win_first"}, int'(win_first), 0);
      chk(win_last == 1'b0, {tag, "_win_last"}, int'(win_last), 0);
      chk(full_done == 1'b0, {tag, "_full_done"}, int'(full_done), 0);
      chk(busy == 1'b0, {tag, "_busy"}, int'(busy), 0);
   endtask

   // PE ready pattern: 0 = always ready, 1 = 1,0,0 repeating, else random.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: rd_ready = 1'b1;
            1: begin
               rd_ready = (rdy_idx % 3 == 0);
               rdy_idx++;
            end
            default: rd_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Compare process: every read, window flag and row release against the model.
   always @(negedge clk) begin
      cyc++;
      hs_now = 0;
      if (rst && chk_en) begin
         if (prev_hs && row_q.size() > 0 && reads_done > 0 && reads_done < row_q[0])
            chk(rd_valid == 1'b1, "no_bubble", int'(rd_valid), 1);
         if (rd_valid) begin
            chk(busy == 1'b1, "busy_in_read", int'(busy), 1);
            if (exp_q.size() == 0) begin
               chk(1'b0, "unexpected_read", int'(IF_raddr), -1);
            end else begin
               chk(int'(IF_raddr) == exp_q[0].addr, "raddr", int'(IF_raddr), exp_q[0].addr);
               chk(win_first == exp_q[0].first, "win_first", int'(win_first), int'(exp_q[0].first));
               chk(win_last == exp_q[0].last, "win_last", int'(win_last), int'(exp_q[0].last));
               if (rd_ready) begin
                  hs_now = 1;
                  void'(exp_q.pop_front());
                  reads_done++;
                  last_hs = cyc;
               end
            end
         end
         if (full_done) begin
            chk(!prev_fd, "done_pulse_width", int'(prev_fd), 0);
            if (row_q.size() == 0) begin
               chk(1'b0, "spurious_full_done", 1, 0);
            end else begin
               chk(reads_done == row_q[0], "reads_per_row", reads_done, row_q[0]);
               if (row_q[0] > 0) chk(cyc - last_hs == 1, "done_latency", cyc - last_hs, 1);
               void'(row_q.pop_front());
               reads_done = 0;
            end
         end
      end
      prev_hs = hs_now;
      prev_fd = full_done && rst && chk_en;
   end

   task automatic push_row(input int base, input int endv, input int f, input int s);
      int n;
      n = model_row(base, endv, f, s);
      foreach (row_buf[i]) exp_q.push_back(row_buf[i]);
      row_q.push_back(n);
      start_IF     = 4'(base);
      end_IF       = 4'(endv);
      filt_len     = 4'(f);
      stride       = 4'(s);
      IF_end_valid = 1'b1;
   endtask

   task automatic run_row(input int base, input int endv, input int f, input int s,
                          input bit scramble, input int gap);
      bit done_seen;
      bit scr_done;
      push_row(base, endv, f, s);
      done_seen = 0;
      scr_done  = 0;
      for (int c = 0; c < 2000 && !done_seen; c++) begin
         @(posedge clk);
         #1;
         if (full_done) begin
            done_seen = 1;
         end else if (scramble && rd_valid && !scr_done) begin
            start_IF = 4'($urandom_range(0, 15));
            end_IF   = 4'($urandom_range(0, 15));
            filt_len = 4'($urandom_range(0, 15));
            stride   = 4'($urandom_range(0, 15));
            scr_done = 1;
         end
      end
      if (!done_seen) begin
         chk(1'b0, "row_timeout", 0, 1);
         finish_now();
      end
      if (gap > 0) begin
         IF_end_valid = 1'b0;
         repeat (gap) @(posedge clk);
         #1;
      end
   endtask

   task automatic run_partial(input int base, input int endv, input int f, input int s, input int stop);
      bool_wait: begin
         bit hit;
         push_row(base, endv, f, s);
         hit = 0;
         for (int c = 0; c < 500 && !hit; c++) begin
            @(posedge clk);
            #1;
            if (reads_done >= stop) hit = 1;
         end
         if (!hit) begin
            chk(1'b0, "partial_timeout", reads_done, stop);
            finish_now();
         end
      end
   endtask

   task automatic clear_model();
      exp_q.delete();
      row_q.delete();
      reads_done = 0;
   endtask

   int pin1[12] = '{0, 1, 2, 1, 2, 3, 2, 3, 4, 3, 4, 5};
   int pin2[6]  = '{14, 15, 0, 1, 2, 3};
   int n;

   initial begin
      // Reset state.
      #1;
      check_zero("reset0");
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset_clocked");
      rst = 1'b1;

      // Pin the model itself with hand-derived sequences.
      n = model_row(0, 5, 3, 1);
      chk(n == 12, "pin1_count", n, 12);
      for (int i = 0; i < 12 && i < n; i++) chk(row_buf[i].addr == pin1[i], "pin1_addr", row_buf[i].addr, pin1[i]);
      chk(row_buf[3].first == 1'b1, "pin1_first", int'(row_buf[3].first), 1);
      chk(row_buf[5].last == 1'b1, "pin1_last", int'(row_buf[5].last), 1);
      n = model_row(14, 3, 2, 2);
      chk(n == 6, "pin2_count", n, 6);
      for (int i = 0; i < 6 && i < n; i++) chk(row_buf[i].addr == pin2[i], "pin2_addr", row_buf[i].addr, pin2[i]);
      n = model_row(0, 2, 4, 1);
      chk(n == 0, "pin3_count", n, 0);
      n = model_row(12, 15, 2, 2);
      chk(n == 4 && row_buf[0].addr == 12, "pin6_first", row_buf[0].addr, 12);
      n = model_row(0, 15, 0, 0);
      chk(n == 16, "pin_full_row", n, 16);

      chk_en = 1;
      rdy_mode = 0;
      run_row(0, 5, 3, 1, 0, 2);      // basic sliding window
      run_row(14, 3, 2, 2, 0, 1);     // wrap across top of buffer
      run_row(0, 2, 4, 1, 0, 1);      // filter wider than row
      run_row(0, 15, 0, 0, 0, 1);     // full-buffer row, zero taps/stride
      rdy_mode = 1;
      rdy_idx  = 0;
      run_row(0, 5, 3, 1, 1, 1);      // stalls, inputs scrambled after latch
      rdy_mode = 0;
      run_row(6, 11, 3, 2, 0, 0);     // next row already buffered
      run_row(12, 15, 2, 2, 0, 2);

      // Asynchronous reset in the middle of a row (o=2, k=1).
      run_partial(0, 5, 3, 1, 7);
      chk(int'(IF_raddr) == 3, "pre_reset_addr", int'(IF_raddr), 3);
      chk_en = 0;
      rst = 1'b0;
      #1;
      check_zero("mid_reset");
      clear_model();
      IF_end_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst   = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      chk_en = 1;
      run_row(0, 5, 3, 1, 0, 1);

      // Synchronous restart mid-row: back to idle, no release pulse.
      run_partial(2, 9, 2, 3, 4);
      chk_en = 0;
      start = 1'b1;
      IF_end_valid = 1'b0;
      @(posedge clk);
      #1;
      chk(busy == 1'b0, "start_busy", int'(busy), 0);
      chk(rd_valid == 1'b0, "start_rd_valid", int'(rd_valid), 0);
      start = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         chk(full_done == 1'b0 && rd_valid == 1'b0, "start_quiet", int'(full_done), 0);
      end
      clear_model();
      chk_en = 1;

      // Randomized rows with random PE backpressure.
      rdy_mode = 2;
      for (int r = 0; r < 40; r++) begin
         run_row($urandom_range(0, 15), $urandom_range(0, 15),
                 ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 5),
                 $urandom_range(0, 4), 1, $urandom_range(0, 3));
      end
      @(posedge clk);
      #1;
      chk(exp_q.size() == 0 && row_q.size() == 0, "drained", exp_q.size() + row_q.size(), 0);
      finish_now();
   end
endmodule
